// File: rtl/perf_pkg.sv
// Shared definitions for the performance-session controller: session states
// and the index of each counter in the performance counter bank.
package perf_pkg;

    localparam int CNT_SEL_W = 4;

    localparam int CNT_CYC      = 0;
    localparam int CNT_INSTR    = 1;
    localparam int CNT_STALL    = 2;
    localparam int CNT_BUBBLE   = 3;
    localparam int CNT_FWD      = 4;
    localparam int CNT_RAW      = 5;
    localparam int CNT_BR       = 6;
    localparam int CNT_BR_TAKEN = 7;
    localparam int CNT_BR_MISP  = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_LOAD  = 3'd4,
        S_WAIT  = 3'd5,
        S_DONE  = 3'd6
    } state_e;

endpackage

// File: rtl/zero_run_detector.sv
// Counts consecutive retired all-zero instruction words. A nonzero retire
// restarts the run, a cycle without a retire leaves it untouched. The count
// saturates at ZERO_RUN so hit stays high until the next clear.
module zero_run_detector #(
    parameter int ZERO_RUN = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        retire_valid,
    input  logic [31:0] retire_instr,
    output logic        hit
);

    localparam int ZW = $clog2(ZERO_RUN + 1);

    logic [ZW-1:0] zero_cnt_q;
    logic [ZW-1:0] zero_cnt_d;

    // Next run length: clear wins, then zero words extend and nonzero words restart
    always_comb begin
        zero_cnt_d = zero_cnt_q;
        if (clr) begin
            zero_cnt_d = '0;
        end else if (retire_valid) begin
            if (retire_instr != 32'h0) begin
                zero_cnt_d = '0;
            end else if (zero_cnt_q != ZW'(ZERO_RUN)) begin
                zero_cnt_d = zero_cnt_q + ZW'(1);
            end
        end
    end

    // Run-length register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_cnt_q <= '0;
        end else begin
            zero_cnt_q <= zero_cnt_d;
        end
    end

    assign hit = (zero_cnt_q == ZW'(ZERO_RUN));

endmodule

// File: rtl/perf_session_ctrl.sv
// Runs one performance-measurement session: clears the counter bank, opens
// the counting window until the program ends (or times out), waits for the
// pipeline to drain, then streams every counter out over a valid/ready port.
module perf_session_ctrl
    import perf_pkg::*;
#(
    parameter int NUM_COUNTERS = CNT_BR_MISP + 1,
    parameter int ZERO_RUN     = 10,
    parameter int DRAIN_CYCLES = 4,
    parameter int MAX_CYCLES   = 1000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 retire_valid,
    input  logic [31:0]          retire_instr,
    output logic                 perf_clear,
    output logic                 perf_enable,
    output logic [CNT_SEL_W-1:0] cnt_sel,
    input  logic [31:0]          cnt_rdata,
    output logic                 dump_valid,
    input  logic                 dump_ready,
    output logic [CNT_SEL_W-1:0] dump_idx,
    output logic [31:0]          dump_data,
    output logic [31:0]          run_cycles,
    output logic                 timeout,
    output logic                 busy,
    output logic                 done
);

    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_SEL_W-1:0] LAST_SEL = CNT_SEL_W'(NUM_COUNTERS - 1);

    state_e               state_q, state_d;
    logic [31:0]          run_cycles_q, run_cycles_d;
    logic                 timeout_q, timeout_d;
    logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic [CNT_SEL_W-1:0] cnt_sel_q, cnt_sel_d;
    logic                 dump_valid_q, dump_valid_d;
    logic [CNT_SEL_W-1:0] dump_idx_q, dump_idx_d;
    logic [31:0]          dump_data_q, dump_data_d;
    logic                 zero_clr;
    logic                 zero_hit;

    // Only retires inside the counting window contribute to the end-of-program run
    zero_run_detector #(
        .ZERO_RUN (ZERO_RUN)
    ) u_zero_run (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (zero_clr),
        .retire_valid (retire_valid && (state_q == S_RUN)),
        .retire_instr (retire_instr),
        .hit          (zero_hit)
    );

    // Session sequencing, window/drain counting and dump word capture
    always_comb begin
        state_d      = state_q;
        run_cycles_d = run_cycles_q;
        timeout_d    = timeout_q;
        drain_cnt_d  = drain_cnt_q;
        cnt_sel_d    = cnt_sel_q;
        dump_valid_d = dump_valid_q;
        dump_idx_d   = dump_idx_q;
        dump_data_d  = dump_data_q;
        zero_clr     = 1'b0;
        if (abort) begin
            state_d      = S_IDLE;
            dump_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d      = S_CLEAR;
                        run_cycles_d = '0;
                        timeout_d    = 1'b0;
                        cnt_sel_d    = '0;
                        drain_cnt_d  = '0;
                        zero_clr     = 1'b1;
                    end
                end
                S_CLEAR: begin
                    state_d = S_RUN;
                end
                S_RUN: begin
                    if (run_cycles_q != 32'hFFFF_FFFF) begin
                        run_cycles_d = run_cycles_q + 32'd1;
                    end
                    if (zero_hit) begin
                        state_d     = S_DRAIN;
                        drain_cnt_d = '0;
                    end else if (run_cycles_d >= 32'(MAX_CYCLES)) begin
                        state_d     = S_DRAIN;
                        drain_cnt_d = '0;
                        timeout_d   = 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt_q == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                        state_d   = S_LOAD;
                        cnt_sel_d = '0;
                    end else begin
                        drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
                    end
                end
                S_LOAD: begin
                    dump_data_d  = cnt_rdata;
                    dump_idx_d   = cnt_sel_q;
                    dump_valid_d = 1'b1;
                    state_d      = S_WAIT;
                end
                S_WAIT: begin
                    if (dump_ready) begin
                        dump_valid_d = 1'b0;
                        if (cnt_sel_q == LAST_SEL) begin
                            state_d = S_DONE;
                        end else begin
                            cnt_sel_d = cnt_sel_q + CNT_SEL_W'(1);
                            state_d   = S_LOAD;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Session state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            run_cycles_q <= '0;
            timeout_q    <= 1'b0;
            drain_cnt_q  <= '0;
            cnt_sel_q    <= '0;
            dump_valid_q <= 1'b0;
            dump_idx_q   <= '0;
            dump_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            run_cycles_q <= run_cycles_d;
            timeout_q    <= timeout_d;
            drain_cnt_q  <= drain_cnt_d;
            cnt_sel_q    <= cnt_sel_d;
            dump_valid_q <= dump_valid_d;
            dump_idx_q   <= dump_idx_d;
            dump_data_q  <= dump_data_d;
        end
    end

    assign perf_clear  = (state_q == S_CLEAR);
    assign perf_enable = (state_q == S_RUN);
    assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done        = (state_q == S_DONE);
    assign cnt_sel     = cnt_sel_q;
    assign dump_valid  = dump_valid_q;
    assign dump_idx    = dump_idx_q;
    assign dump_data   = dump_data_q;
    assign run_cycles  = run_cycles_q;
    assign timeout     = timeout_q;

endmodule
